// File: rtl/bpsk_demod.sv
// Coherent BPSK demodulator: correlates offset-binary samples against an internal sine
// reference over one symbol, slices the sign and packs bits MSB-first into output words.
module bpsk_demod #(
  parameter int unsigned SAMPLE_NUMBER = 256,
  parameter int unsigned SAMPLE_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH    = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [SAMPLE_WIDTH-1:0] signal_in,
  output logic [DATA_WIDTH-1:0]   q
);

  localparam int unsigned CntW = $clog2(SAMPLE_NUMBER);
  localparam int unsigned SelW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned AccW = 2 * SAMPLE_WIDTH + CntW + 1;
  localparam int          Mid  = 2 ** (SAMPLE_WIDTH - 1);
  localparam logic [SAMPLE_WIDTH-1:0] MidVec = {1'b1, {(SAMPLE_WIDTH - 1){1'b0}}};

  // Only the first half-period is evaluated; the second half is its exact negation so the
  // reference sums to zero over a period and DC offsets never leak into the correlation.
  function automatic logic signed [SAMPLE_WIDTH-1:0] ref_val(input int k);
    real pi;
    real amp;
    int  kk;
    int  v;
    pi  = 3.14159265358979323846;
    kk  = (k > int'(SAMPLE_NUMBER / 2)) ? int'(SAMPLE_NUMBER) - k : k;
    amp = real'(Mid - 1) * $sin(2.0 * pi * real'(kk) / real'(SAMPLE_NUMBER));
    v   = $rtoi(amp + 0.5);
    if (k > int'(SAMPLE_NUMBER / 2)) v = -v;
    return v[SAMPLE_WIDTH-1:0];
  endfunction

  logic signed [SAMPLE_WIDTH-1:0] rom [SAMPLE_NUMBER];

  for (genvar k = 0; k < int'(SAMPLE_NUMBER); k++) begin : g_rom
    assign rom[k] = ref_val(k);
  end

  logic [CntW-1:0]              sample_cnt_q, sample_cnt_d;
  logic [SelW-1:0]              sel_cnt_q, sel_cnt_d;
  logic signed [AccW-1:0]       acc_q, acc_d;
  logic [DATA_WIDTH-1:0]        shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0]        q_q, q_d;
  logic                         flag_q, flag_d;

  logic signed [SAMPLE_WIDTH-1:0] ref_cur;
  logic signed [SAMPLE_WIDTH:0]   s;
  logic signed [2*SAMPLE_WIDTH:0] prod;
  logic signed [AccW-1:0]         acc_sum;
  logic                           sym_bit;

  logic [SAMPLE_WIDTH-1:0] sel;
  logic [SelW-1:0]         sel_cnt;
  logic                    flag;

  assign ref_cur = rom[sample_cnt_q];
  assign sel     = $unsigned(ref_cur) + MidVec;
  assign s       = $signed({1'b0, signal_in}) - $signed({1'b0, MidVec});
  assign prod    = s * ref_cur;
  assign acc_sum = acc_q + AccW'(prod);
  // A zero correlation counts as non-negative and slices to 1.
  assign sym_bit = ~acc_sum[AccW-1];

  always_comb begin
    sample_cnt_d = sample_cnt_q;
    sel_cnt_d    = sel_cnt_q;
    acc_d        = acc_q;
    shreg_d      = shreg_q;
    q_d          = q_q;
    flag_d       = 1'b0;
    if (en) begin
      sample_cnt_d = sample_cnt_q + CntW'(1);
      acc_d        = acc_sum;
      if (sample_cnt_q == CntW'(SAMPLE_NUMBER - 1)) begin
        acc_d   = '0;
        shreg_d = {shreg_q[DATA_WIDTH-2:0], sym_bit};
        if (sel_cnt_q == SelW'(DATA_WIDTH - 1)) begin
          q_d       = shreg_d;
          flag_d    = 1'b1;
          sel_cnt_d = '0;
        end else begin
          sel_cnt_d = sel_cnt_q + SelW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt_q <= '0;
      sel_cnt_q    <= '0;
      acc_q        <= '0;
      shreg_q      <= '0;
      q_q          <= '0;
      flag_q       <= 1'b0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      sel_cnt_q    <= sel_cnt_d;
      acc_q        <= acc_d;
      shreg_q      <= shreg_d;
      q_q          <= q_d;
      flag_q       <= flag_d;
    end
  end

  assign sel_cnt = sel_cnt_q;
  assign flag    = flag_q;
  assign q       = q_q;

endmodule

// File: tb/tb_bpsk_demod.sv
// Self-checking bench for bpsk_demod: per-symbol correlation model over random and
// modulated sample streams, checking words, flag pulses, sel/sel_cnt and reset behaviour.
module tb_bpsk_demod;

  logic        clk;
  logic        rst;
  logic        en;
  logic [11:0] signal_in;
  logic [11:0] q;

  int errors = 0;
  int checks = 0;
  int ref_tab [256];
  logic [11:0] last_q;

  bpsk_demod dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .signal_in(signal_in),
    .q        (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_ref(input int k);
    real v;
    int  r;
    int  kk;
    kk = (k > 128) ? 256 - k : k;
    v  = 2047.0 * $sin(2.0 * 3.14159265358979323846 * real'(kk) / 256.0);
    r  = $rtoi(v + 0.5);
    return (k > 128) ? -r : r;
  endfunction

  // mode 0: DC 0x7CE, 1: clean modulation of pat, 2: modulation plus noise, 3: random samples
  task automatic send_word(input logic [11:0] pat, input int mode, input int nsym,
                           input int gap_sym, input int gap_smp, input int gap_len);
    longint      corr;
    logic [11:0] mword;
    int          extra;
    int          x;
    int          r;
    int          bitv;
    mword = '0;
    extra = 0;
    for (int s = 0; s < nsym; s++) begin
      corr = 0;
      bitv = pat[11-s] ? 1 : -1;
      for (int k = 0; k < 256; k++) begin
        if (s == gap_sym && k == gap_smp) begin
          en = 1'b0;
          for (int g = 0; g < gap_len; g++) begin
            signal_in = 12'($urandom);
            @(posedge clk); #1;
            if (flag_seen()) extra++;
          end
        end
        r = ref_tab[k];
        case (mode)
          0:       x = 12'h7CE;
          1:       x = (pat[11-s]) ? r + 2048 : (4096 - (r + 2048)) % 4096;
          2: begin
            x = 2048 + bitv * r + int'($urandom_range(0, 600)) - 300;
            if (x < 0) x = 0;
            if (x > 4095) x = 4095;
          end
          default: x = int'($urandom_range(0, 4095));
        endcase
        if (k == (s * 37 + 5) % 256) begin
          checks++;
          if (dut.sel !== 12'((r + 2048) % 4096)) begin
            errors++;
            $display("FAIL sel sym%0d k%0d: got %h want %h", s, k, dut.sel, 12'(r + 2048));
          end
        end
        en        = 1'b1;
        signal_in = 12'(x);
        corr += longint'(x - 2048) * longint'(r);
        @(posedge clk); #1;
        if (s == 0 && k == 1) begin
          checks++;
          if (q !== last_q) begin
            errors++;
            $display("FAIL q_hold: got %h want %h", q, last_q);
          end
        end
        if (k == 255) begin
          mword = {mword[10:0], (corr >= 0)};
          if (s < 11) begin
            checks++;
            if (dut.sel_cnt !== 4'(s + 1)) begin
              errors++;
              $display("FAIL sel_cnt sym%0d: got %0d want %0d", s, dut.sel_cnt, s + 1);
            end
          end
        end
        if (s == 11 && k == 255) begin
          checks++;
          if (q !== mword || dut.flag !== 1'b1 || dut.sel_cnt !== 4'd0) begin
            errors++;
            $display("FAIL word_end: q=%h flag=%b sel_cnt=%0d want q=%h flag=1 sel_cnt=0",
                     q, dut.flag, dut.sel_cnt, mword);
          end
          checks++;
          if (extra != 0) begin
            errors++;
            $display("FAIL stray_flag: got %0d extra pulses want 0", extra);
          end
          last_q = mword;
        end else if (flag_seen()) begin
          extra++;
        end
      end
    end
  endtask

  function automatic bit flag_seen();
    return dut.flag !== 1'b0;
  endfunction

  task automatic idle_check_flag(input string name);
    en        = 1'b0;
    signal_in = 12'($urandom);
    @(posedge clk); #1;
    checks++;
    if (dut.flag !== 1'b0 || q !== last_q) begin
      errors++;
      $display("FAIL %s: flag=%b q=%h want flag=0 q=%h", name, dut.flag, q, last_q);
    end
  endtask

  task automatic check_reset_state(input string name);
    checks++;
    if (q !== 12'h000 || dut.sel !== 12'h800 || dut.sel_cnt !== 4'd0 || dut.flag !== 1'b0) begin
      errors++;
      $display("FAIL %s: q=%h sel=%h sel_cnt=%0d flag=%b want 000/800/0/0",
               name, q, dut.sel, dut.sel_cnt, dut.flag);
    end
  endtask

  task automatic test_reset();
    en = 1'b0;
    signal_in = 12'h000;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_state("reset_async");
    @(posedge clk); #1;
    check_reset_state("reset_held");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    last_q = 12'h000;
  endtask

  task automatic test_dc();
    send_word(12'h000, 0, 12, -1, 0, 0);
    idle_check_flag("dc_flag_drop");
  endtask

  task automatic test_modulated();
    send_word(12'hB38, 1, 12, -1, 0, 0);
    idle_check_flag("mod_b38_flag_drop");
    send_word(12'h000, 1, 12, -1, 0, 0);
    idle_check_flag("mod_000_flag_drop");
  endtask

  task automatic test_enable_gaps();
    send_word(12'hB38, 1, 12, 6, 100, 100);
    idle_check_flag("gap_mid_flag_drop");
    send_word(12'hB38, 1, 12, 4, 0, 100);
    idle_check_flag("gap_bound_flag_drop");
  endtask

  task automatic test_reset_mid_word();
    send_word(12'h3C3, 1, 5, -1, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_state("reset_mid_word");
    @(negedge clk);
    rst    = 1'b0;
    last_q = 12'h000;
    send_word(12'hA5A, 1, 12, -1, 0, 0);
    idle_check_flag("after_reset_flag_drop");
  endtask

  task automatic test_back_to_back();
    send_word(12'hFFF, 1, 12, -1, 0, 0);
    send_word(12'h001, 1, 12, -1, 0, 0);
    idle_check_flag("b2b_flag_drop");
  endtask

  task automatic test_random();
    for (int w = 0; w < 2; w++) send_word(12'($urandom), 2, 12, w * 3 + 1, 7 + w * 50, 13);
    for (int w = 0; w < 2; w++) send_word(12'h000, 3, 12, -1, 0, 0);
    idle_check_flag("random_flag_drop");
  endtask

  initial begin
    for (int k = 0; k < 256; k++) ref_tab[k] = model_ref(k);
    last_q = 12'h000;
    test_reset();
    test_dc();
    test_modulated();
    test_enable_gaps();
    test_reset_mid_word();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bpsk_demod.md
Name: bpsk_demod

Overview:
Coherent BPSK receiver back-end. Correlates an offset-binary sampled carrier against an internal sine reference over one symbol period of SAMPLE_NUMBER samples, then slices the sign of the correlation to one bit. It packs DATA_WIDTH bits MSB-first into a parallel output word. It sits after the ADC/sampler and pairs with the team's BPSK modulator: +sine encodes 1, −sine encodes 0.

Parameters:
SAMPLE_NUMBER, 256, samples per carrier period = samples per symbol; power of two ≥ 4
SAMPLE_WIDTH, 12, width of signal_in and of reference samples
DATA_WIDTH, 12, bits per output word

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  sample enable; one sample is consumed per clk edge with en=1
signal_in  input  SAMPLE_WIDTH  received sample, unsigned offset-binary, midscale M = 2^(SAMPLE_WIDTH-1)
q  output  DATA_WIDTH  last completely demodulated word

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high; all state clears immediately on rst=1.
- Reset values:
  - q = 0, shift register = 0.
  - Sample counter = 0, sel_cnt = 0, accumulator = 0, flag = 0.
- Reference ROM, internal, SAMPLE_NUMBER entries, signed:
  - ref[k] = round((M−1)·sin(2πk/SAMPLE_NUMBER)).
  - ref[N−k] = −ref[k] exactly, so the sum over a period is 0.
- Internal observable signals (names fixed; benches probe them hierarchically):
  - sel: SAMPLE_WIDTH bits, combinational = ref[sample_cnt] + M, offset-binary; 0x800 at reset.
  - sel_cnt: ceil(log2(DATA_WIDTH)) bits, the bit index within the current word.
  - flag: one-cycle word-valid pulse.
- Per enabled edge:
  - s = signal_in − M, signed SAMPLE_WIDTH+1 bits.
  - acc_next = acc + s·ref[sample_cnt].
  - Accumulator width = 2·SAMPLE_WIDTH + log2(SAMPLE_NUMBER) + 1; no overflow possible.
  - sample_cnt increments and wraps N−1 → 0.
- Symbol end, on the enabled edge where sample_cnt = N−1:
  - bit = (acc_next ≥ 0) ? 1 : 0; a tie (0) slices to 1.
  - acc ← 0.
  - Shift register ← {shreg[DW−2:0], bit}; the first bit of a word ends up as the MSB.
- Word end, when sel_cnt = DATA_WIDTH−1 at symbol end:
  - q ← {shreg[DW−2:0], bit}; flag ← 1 for exactly that next cycle; sel_cnt ← 0.
  - Otherwise sel_cnt increments at each symbol end.
- Latency: q updates on the same edge that consumes the last sample of the word, i.e. the DATA_WIDTH·SAMPLE_NUMBER-th enabled sample (3072 with defaults).
- flag is 0 in all other cycles.
- en=0: all state holds, signal_in is ignored, and flag drops to 0. Gaps of any length mid-symbol are transparent.
- No carrier/symbol synchronisation: symbol timing is defined solely by the enabled-sample count since reset.
- q holds its value between words.
- rst mid-word: the partial word is discarded; the next word starts at sample 0 with sel_cnt 0.

Test Plan:
1. Reset check: assert rst → q=0x000, sel=0x800, sel_cnt=0, flag=0, independent of clk.
2. DC input: rst low, en=1, signal_in=0x7CE constant for 3072 cycles.
   - Every correlation is 0, so each bit slices to 1.
   - q=0xFFF on edge 3072; flag high for exactly one cycle.
   - sel_cnt steps 0→11 every 256 cycles and then returns to 0.
3. Modulated word: per symbol, drive signal_in=sel for a 1 bit and (4096−sel) mod 4096 for a 0 bit, with pattern 1011_0011_1000.
   - q=0xB38 after 3072 cycles with a single flag pulse.
   - The following all-0 pattern gives q=0x000.
4. Enable gaps: repeat scenario 3 with en deasserted for 100 cycles in mid-symbol and at a symbol boundary → identical q=0xB38. flag is only asserted on the final enabled edge.
5. Reset mid-word:
   - Assert rst after 5 symbols of a word.
   - Then send a full 0xA5A word.
   - q=0xA5A with no residue from the aborted word; q reads 0 between the reset and completion.
6. Back-to-back words: 0xFFF then 0x001 continuously → flag pulses at cycles 3072 and 6144, and q shows those values in order.
